// File: rtl/rr_encoder_arbiter_if.sv
// rtl/rr_encoder_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_encoder_arbiter_if;
  logic       En;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [2:0] ptr;

  modport master (
    output En,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  ptr
  );

  modport slave (
    input  En,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output ptr
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// rtl/rr_encoder_arbiter.sv - 8-requester round-robin arbiter with bounded tenure and encoded grant
module rr_encoder_arbiter #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_encoder_arbiter_if.slave  bus
);

  localparam int unsigned IW = 3;
  localparam int unsigned HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit          LIMITED = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic               tenure_done;

  // Pick the first requester at or after ptr; scanning offsets from high to low lets the nearest one win.
  always_comb begin
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IW'(k);
      if (bus.req[cand] == 1'b1) begin
        win_idx = cand;
      end
    end
  end

  assign tenure_done = LIMITED && (hold_q == HW'(MAX_HOLD));

  // Next-state and next-output decision; En is always tested first so X on req cannot leak while disabled.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
        if (bus.En && (bus.req != '0)) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (!bus.En) begin
          // revoked: priority does not advance
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (!bus.req[idx_q] || tenure_done) begin
          // completed tenure: the owner drops to lowest priority
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          ptr_d   = idx_q + IW'(1);
        end else if (LIMITED && (hold_q < HW'(MAX_HOLD))) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers; reset overrides everything including an active tenure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// tb/tb_rr_encoder_arbiter.sv - directed plus randomized checks of rr_encoder_arbiter against a reference model
module tb_rr_encoder_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  // reference model: owner = -1 means nobody holds the resource
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_encoder_arbiter_if bus ();

  rr_encoder_arbiter #(.N_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r_rst, input logic e, input logic [7:0] r);
    int  idx;
    bit  found;
    if (r_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (e == 1'b1 && r != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr + k) % 8;
          if (!found && r[idx] == 1'b1) begin
            found   = 1;
            m_owner = idx;
          end
        end
        m_hold = 1;
      end
    end else begin
      if (e != 1'b1) begin
        m_owner = -1;
        m_hold  = 0;
      end else if (r[m_owner] != 1'b1 || (MAX_HOLD != 0 && m_hold == MAX_HOLD)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic compare_model(input string where);
    logic [7:0] e_gnt;
    logic [7:0] e_idx;
    logic [7:0] e_val;
    logic [7:0] e_ptr;
    e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    e_idx = (m_owner < 0) ? 8'h00 : 8'(m_owner);
    e_val = (m_owner < 0) ? 8'h00 : 8'h01;
    e_ptr = 8'(m_ptr);
    check({where, ".gnt"},       bus.gnt,                 e_gnt);
    check({where, ".gnt_idx"},   {5'b0, bus.gnt_idx},     e_idx);
    check({where, ".gnt_valid"}, {7'b0, bus.gnt_valid},   e_val);
    check({where, ".ptr"},       {5'b0, bus.ptr},         e_ptr);
  endtask

  // drive inputs away from the edge, clock once, sample 1 time unit after the edge
  task automatic cycle(input string where, input logic r_rst, input logic e, input logic [7:0] r);
    rst     = r_rst;
    bus.En  = e;
    bus.req = r;
    model_step(r_rst, e, r);
    @(posedge clk);
    #1;
    compare_model(where);
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] saved_ptr;
    logic [7:0] xreq;
    bus.En  = 1'b0;
    bus.req = 8'h00;
    #2;

    // reset and idle
    cycle("reset0", 1'b1, 1'b0, 8'h00);
    cycle("reset1", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b1, 8'h00);
    check("idle_ptr", {5'b0, bus.ptr}, 8'd0);

    // basic rotation between requesters 0 and 7
    for (int i = 1; i <= 11; i++) begin
      cycle("rotate", 1'b0, 1'b1, 8'h81);
      if (i == 1)  check("rot_first_idx", {5'b0, bus.gnt_idx}, 8'd0);
      if (i == 5)  check("rot_gap_valid", {7'b0, bus.gnt_valid}, 8'd0);
      if (i == 6)  check("rot_second_idx", {5'b0, bus.gnt_idx}, 8'd7);
      if (i == 10) check("rot_gap_ptr", {5'b0, bus.ptr}, 8'd0);
      if (i == 11) check("rot_third_gnt", bus.gnt, 8'h01);
    end
    cycle("rot_drop", 1'b0, 1'b1, 8'h00);

    // early release of requester 2
    cycle("early0", 1'b0, 1'b1, 8'h04);
    cycle("early1", 1'b0, 1'b1, 8'h04);
    check("early_gnt", bus.gnt, 8'h04);
    cycle("early2", 1'b0, 1'b1, 8'h00);
    check("early_ptr", {5'b0, bus.ptr}, 8'd3);

    // wrap-around: release idx6 so ptr=7, then idx1 must beat idx6
    cycle("wrap0", 1'b0, 1'b1, 8'h40);
    cycle("wrap1", 1'b0, 1'b1, 8'h00);
    check("wrap_ptr", {5'b0, bus.ptr}, 8'd7);
    cycle("wrap2", 1'b0, 1'b1, 8'h42);
    check("wrap_winner", {5'b0, bus.gnt_idx}, 8'd1);
    cycle("wrap3", 1'b0, 1'b1, 8'h00);

    // enable revoke mid-grant of idx5
    cycle("revoke0", 1'b0, 1'b1, 8'h20);
    cycle("revoke1", 1'b0, 1'b1, 8'h20);
    saved_ptr = {5'b0, bus.ptr};
    cycle("revoke2", 1'b0, 1'b0, 8'h20);
    check("revoke_valid", {7'b0, bus.gnt_valid}, 8'd0);
    check("revoke_ptr", {5'b0, bus.ptr}, saved_ptr);
    cycle("revoke3", 1'b0, 1'b1, 8'h20);
    check("revoke_regrant", {5'b0, bus.gnt_idx}, 8'd5);

    // simultaneous En fall and owner drop leaves ptr alone
    saved_ptr = {5'b0, bus.ptr};
    cycle("simul", 1'b0, 1'b0, 8'h00);
    check("simul_ptr", {5'b0, bus.ptr}, saved_ptr);
    cycle("simul_re", 1'b0, 1'b1, 8'h20);

    // reset mid-tenure, then X requests while disabled
    cycle("rst_mid", 1'b1, 1'b1, 8'h20);
    check("rst_mid_gnt", bus.gnt, 8'h00);
    xreq = 8'bxxxx_xxxx;
    for (int i = 0; i < 3; i++) begin
      cycle("xreq", 1'b0, 1'b0, xreq);
      check("xreq_idx", {5'b0, bus.gnt_idx}, 8'd0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rq = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 8'h00;
      cycle("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
